// File: rtl/minisrc_pkg.sv
// Shared constants for the Mini SRC control sequencer: IR field positions,
// opcode values and the sequencer state encoding.
package minisrc_pkg;

  // IR field bit positions
  localparam int IR_OP_HI = 31;
  localparam int IR_OP_LO = 27;
  localparam int IR_RA_HI = 26;
  localparam int IR_RA_LO = 23;
  localparam int IR_RB_HI = 22;
  localparam int IR_RB_LO = 19;
  localparam int IR_RC_HI = 18;
  localparam int IR_RC_LO = 15;

  // Opcodes
  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SUB  = 5'b00001;
  localparam logic [4:0] OP_AND  = 5'b00010;
  localparam logic [4:0] OP_OR   = 5'b00011;
  localparam logic [4:0] OP_SHR  = 5'b00100;
  localparam logic [4:0] OP_SHRA = 5'b00101;
  localparam logic [4:0] OP_SHL  = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_T0      = 4'd1,
    S_T1      = 4'd2,
    S_T2      = 4'd3,
    S_T3      = 4'd4,
    S_T4      = 4'd5,
    S_T5      = 4'd6,
    S_T6      = 4'd7,
    S_HALT    = 4'd8,
    S_ILLEGAL = 4'd9
  } state_e;

endpackage

// File: rtl/minisrc_op_decode.sv
// Opcode classifier: legal ALU op / HALT / MUL-DIV.
// Build option MINISRC_MULDIV_EN: when undefined, MUL and DIV are illegal.
module minisrc_op_decode
  import minisrc_pkg::*;
(
  input  logic [4:0] op,
  output logic       legal,
  output logic       halt,
  output logic       muldiv
);

  // Classify the opcode; HALT is not counted as a legal ALU op
  always_comb begin
    legal  = 1'b0;
    halt   = 1'b0;
    muldiv = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR,
      OP_SHRA, OP_SHL, OP_ROR, OP_ROL: legal = 1'b1;
`ifdef MINISRC_MULDIV_EN
      OP_MUL, OP_DIV: begin
        legal  = 1'b1;
        muldiv = 1'b1;
      end
`else
      OP_MUL, OP_DIV: legal = 1'b0;  // no HI/LO path in this build
`endif
      OP_HALT: halt = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/minisrc_control_seq.sv
// Moore control sequencer for the Mini SRC datapath: fetch T0-T2 with a
// memory-ready wait in T1, execute T3-T6 for register-to-register ALU ops.
// Build option MINISRC_MULDIV_EN enables the MUL/DIV Z -> LO/HI path (T6).
module minisrc_control_seq
  import minisrc_pkg::*;
(
  input  logic        clk,
  input  logic        clr,
  input  logic        run,
  input  logic        mem_rdy,
  input  logic [31:0] ir,
  output logic        PCout,
  output logic        MARin,
  output logic        IncPC,
  output logic        PCin,
  output logic        Read,
  output logic        MDRin,
  output logic        MDRout,
  output logic        IRin,
  output logic        Yin,
  output logic        Zlowin,
  output logic        ZHighin,
  output logic        Zlowout,
  output logic        ZHighout,
  output logic        HIin,
  output logic        LOin,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic [4:0]  operation,
  output logic        instr_done,
  output logic        halted,
  output logic        illegal
);

  state_e     state_q, state_d;
  logic [4:0] op;
  logic       op_legal, op_halt, op_muldiv;

  assign op = ir[IR_OP_HI:IR_OP_LO];

  // Register fields are consumed by the datapath's select-and-encode logic
  logic unused_ir_fields;
  assign unused_ir_fields = ^{ir[IR_RA_HI:IR_RA_LO], ir[IR_RB_HI:IR_RB_LO],
                              ir[IR_RC_HI:IR_RC_LO], ir[IR_RC_LO-1:0]};

  minisrc_op_decode u_op_decode (
    .op     (op),
    .legal  (op_legal),
    .halt   (op_halt),
    .muldiv (op_muldiv)
  );

  // State register; clr wins over every other input
  always_ff @(posedge clk) begin
    // NOTE: state flops use non-blocking assignment so every flop samples pre-edge values
    if (clr) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; run is only looked at in IDLE and on the last execute cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (run) state_d = S_T0;
      S_T0:      state_d = S_T1;
      S_T1:      if (mem_rdy) state_d = S_T2;
      S_T2:      state_d = S_T3;
      S_T3: begin
        if (op_halt)       state_d = S_HALT;
        else if (op_legal) state_d = S_T4;
        else               state_d = S_ILLEGAL;
      end
      S_T4:      state_d = S_T5;
      S_T5: begin
        if (op_muldiv) state_d = S_T6;
        else           state_d = run ? S_T0 : S_IDLE;
      end
      S_T6:      state_d = run ? S_T0 : S_IDLE;
      S_HALT:    state_d = S_HALT;
      S_ILLEGAL: state_d = S_ILLEGAL;
      default:   state_d = S_IDLE;
    endcase
  end

  // Output decode from the state register and the IR opcode
  always_comb begin
    // NOTE: every output is defaulted first so no branch of the case can infer a latch
    {PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin, Yin,
     Zlowin, ZHighin, Zlowout, ZHighout, HIin, LOin,
     Gra, Grb, Grc, Rin, Rout, instr_done, halted, illegal} = '0;
    operation = '0;
    case (state_q)
      S_T0: begin
        PCout  = 1'b1;
        MARin  = 1'b1;
        IncPC  = 1'b1;
        Zlowin = 1'b1;
      end
      S_T1: begin
        Zlowout = 1'b1;
        PCin    = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
      end
      S_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      S_T3: begin
        if (op_legal) begin
          Grb  = 1'b1;
          Rout = 1'b1;
          Yin  = 1'b1;
        end
      end
      S_T4: begin
        Grc       = 1'b1;
        Rout      = 1'b1;
        Zlowin    = 1'b1;
        ZHighin   = op_muldiv;
        operation = op;
      end
      S_T5: begin
        Zlowout = 1'b1;
        if (op_muldiv) begin
          LOin = 1'b1;
        end else begin
          Gra        = 1'b1;
          Rin        = 1'b1;
          instr_done = 1'b1;
        end
      end
      S_T6: begin
        ZHighout   = 1'b1;
        HIin       = 1'b1;
        instr_done = 1'b1;
      end
      S_HALT:    halted  = 1'b1;
      S_ILLEGAL: illegal = 1'b1;
      default: ;
    endcase
`ifndef MINISRC_MULDIV_EN
    ZHighin  = 1'b0;
    ZHighout = 1'b0;
    HIin     = 1'b0;
    LOin     = 1'b0;
`endif
  end

endmodule

// File: tb/tb_minisrc_control_seq.sv
// Self-checking bench for minisrc_control_seq. Expectations follow the
// MINISRC_MULDIV_EN setting of the build.
module tb_minisrc_control_seq;

`ifdef MINISRC_MULDIV_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        clr, run, mem_rdy;
  logic [31:0] ir;
  logic PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin, Yin;
  logic Zlowin, ZHighin, Zlowout, ZHighout, HIin, LOin;
  logic Gra, Grb, Grc, Rin, Rout, instr_done, halted, illegal;
  logic [4:0] operation;

  always #5 clk = ~clk;

  minisrc_control_seq dut (
    .clk(clk), .clr(clr), .run(run), .mem_rdy(mem_rdy), .ir(ir),
    .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .PCin(PCin), .Read(Read),
    .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin),
    .Zlowin(Zlowin), .ZHighin(ZHighin), .Zlowout(Zlowout), .ZHighout(ZHighout),
    .HIin(HIin), .LOin(LOin), .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin),
    .Rout(Rout), .operation(operation), .instr_done(instr_done),
    .halted(halted), .illegal(illegal)
  );

  typedef struct packed {
    logic PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin, Yin;
    logic Zlowin, ZHighin, Zlowout, ZHighout, HIin, LOin;
    logic Gra, Grb, Grc, Rin, Rout, instr_done, halted, illegal;
    logic [4:0] operation;
  } outs_t;

  // One cycle: expected outputs during the cycle, then inputs for the closing edge
  typedef struct {
    string       name;
    outs_t       exp;
    logic        run;
    logic        rdy;
    logic        clr;
    logic        ld;
    logic [31:0] irv;
  } step_t;

  outs_t act;
  assign act = {PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin, Yin,
                Zlowin, ZHighin, Zlowout, ZHighout, HIin, LOin,
                Gra, Grb, Grc, Rin, Rout, instr_done, halted, illegal, operation};

  // Phase codes used only to name expected output sets
  localparam int P_IDLE = 0, P_T0 = 1, P_T1 = 2, P_T2 = 3, P_T3 = 4, P_T4 = 5;
  localparam int P_T5N = 6, P_T5M = 7, P_T6 = 8, P_HALT = 9, P_ILL = 10;

  step_t steps[$];
  int    n_vec = 0;
  int    n_err = 0;
  bit    in_idle = 1'b1;

  function automatic bit is_md(input logic [4:0] op);
    return MD_EN && (op == 5'd15 || op == 5'd16);
  endfunction

  function automatic bit is_alu(input logic [4:0] op);
    return (op <= 5'd8) || is_md(op);
  endfunction

  function automatic outs_t out_of(input int p, input logic [4:0] op);
    outs_t e;
    e = '0;
    case (p)
      P_T0:   begin e.PCout = 1; e.MARin = 1; e.IncPC = 1; e.Zlowin = 1; end
      P_T1:   begin e.Zlowout = 1; e.PCin = 1; e.Read = 1; e.MDRin = 1; end
      P_T2:   begin e.MDRout = 1; e.IRin = 1; end
      P_T3:   begin e.Grb = 1; e.Rout = 1; e.Yin = 1; end
      P_T4:   begin
        e.Grc = 1; e.Rout = 1; e.Zlowin = 1; e.operation = op;
        e.ZHighin = is_md(op);
      end
      P_T5N:  begin e.Zlowout = 1; e.Gra = 1; e.Rin = 1; e.instr_done = 1; end
      P_T5M:  begin e.Zlowout = 1; e.LOin = 1; end
      P_T6:   begin e.ZHighout = 1; e.HIin = 1; e.instr_done = 1; end
      P_HALT: e.halted = 1;
      P_ILL:  e.illegal = 1;
      default: ;
    endcase
    return e;
  endfunction

  task automatic push(input string nm, input outs_t e, input logic r, input logic rd,
                      input logic c, input logic ld, input logic [31:0] v);
    step_t s;
    s.name = nm; s.exp = e; s.run = r; s.rdy = rd; s.clr = c; s.ld = ld; s.irv = v;
    steps.push_back(s);
  endtask

  // Reference model: expands one instruction into its expected cycle trace.
  // clr_ph: execute/fetch tag (0..6) at which clr is applied, -1 for none.
  task automatic gen_instr(input logic [31:0] ir_v, input int waits, input bit run_end,
                           input int clr_ph, input int sticky_n);
    outs_t       ph[$];
    int          tg[$];
    string       nm[8] = '{"T0", "T1", "T2", "T3", "T4", "T5", "T6", "sticky"};
    logic [4:0]  op;
    bit          hlt, alu, md, stop, last, rdy_v;
    int          n;
    op  = ir_v[31:27];
    hlt = (op == 5'b11011);
    alu = is_alu(op);
    md  = is_md(op);
    stop = hlt || !alu;
    if (in_idle) begin
      n = $urandom_range(0, 2);
      for (int k = 0; k < n; k++) push("idle", '0, 1'b0, 1'($urandom), 1'b0, 1'b0, 32'h0);
      push("idle go", '0, 1'b1, 1'($urandom), 1'b0, 1'b0, 32'h0);
    end
    ph.push_back(out_of(P_T0, op)); tg.push_back(0);
    for (int w = 0; w <= waits; w++) begin ph.push_back(out_of(P_T1, op)); tg.push_back(1); end
    ph.push_back(out_of(P_T2, op)); tg.push_back(2);
    if (stop) begin
      ph.push_back('0); tg.push_back(3);
      for (int k = 0; k < sticky_n; k++) begin
        ph.push_back(out_of(hlt ? P_HALT : P_ILL, op)); tg.push_back(7);
      end
    end else begin
      ph.push_back(out_of(P_T3, op)); tg.push_back(3);
      ph.push_back(out_of(P_T4, op)); tg.push_back(4);
      if (md) begin
        ph.push_back(out_of(P_T5M, op)); tg.push_back(5);
        ph.push_back(out_of(P_T6, op));  tg.push_back(6);
      end else begin
        ph.push_back(out_of(P_T5N, op)); tg.push_back(5);
      end
    end
    for (int i = 0; i < ph.size(); i++) begin
      last  = (i == ph.size() - 1);
      rdy_v = (tg[i] == 1) ? (last || tg[i+1] != 1) : 1'($urandom);
      if (tg[i] == clr_ph) begin
        push({nm[tg[i]], " clr"}, ph[i], 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        in_idle = 1'b1;
        return;
      end
      if (last && stop) begin
        push({nm[tg[i]], " clr"}, ph[i], 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        in_idle = 1'b1;
      end else if (last) begin
        push(nm[tg[i]], ph[i], run_end, 1'($urandom), 1'b0, 1'b0, 32'h0);
        in_idle = !run_end;
      end else begin
        push(nm[tg[i]], ph[i], (tg[i] == 7) ? 1'b1 : 1'($urandom), rdy_v, 1'b0,
             (tg[i] == 2), ir_v);
      end
    end
  endtask

  task automatic check(input string nm, input outs_t got, input outs_t want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s (vector %0d): outputs %h, required %h", nm, n_vec, got, want);
    end
  endtask

  task automatic run_steps();
    step_t s;
    while (steps.size() > 0) begin
      s = steps.pop_front();
      @(negedge clk);
      check(s.name, act, s.exp);
      run = s.run; mem_rdy = s.rdy; clr = s.clr;
      if (s.ld) ir = s.irv;
    end
  endtask

  step_t      tbl[9];
  logic [4:0] legal_ops[11] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8,
                                5'd15, 5'd16};
  logic [4:0] rop;
  int         pick;

  initial begin
    clr = 1'b1; run = 1'b0; mem_rdy = 1'b0; ir = 32'h0;
    repeat (2) @(posedge clk);

    // Reset/idle followed by ADD R5,R2,R4 with run for one cycle
    tbl[0] = '{"reset idle", out_of(P_IDLE, 5'd0), 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[1] = '{"idle go",    out_of(P_IDLE, 5'd0), 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[2] = '{"add T0",     out_of(P_T0, 5'd0),   1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[3] = '{"add T1",     out_of(P_T1, 5'd0),   1'b0, 1'b1, 1'b0, 1'b0, 32'h0};
    tbl[4] = '{"add T2",     out_of(P_T2, 5'd0),   1'b0, 1'b0, 1'b0, 1'b1, 32'h02920000};
    tbl[5] = '{"add T3",     out_of(P_T3, 5'd0),   1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[6] = '{"add T4",     out_of(P_T4, 5'd0),   1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[7] = '{"add T5",     out_of(P_T5N, 5'd0),  1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[8] = '{"add idle",   out_of(P_IDLE, 5'd0), 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    for (int i = 0; i < 9; i++) steps.push_back(tbl[i]);

    // Multi-cycle corner cases
    gen_instr(32'h80120000, 0, 1'b0, -1, 4);   // DIV (illegal without MUL/DIV)
    gen_instr(32'h02920000, 3, 1'b0, -1, 0);   // memory wait of 3 cycles
    gen_instr(32'hD8000000, 0, 1'b0, -1, 10);  // HALT, sticky, then clr
    gen_instr(32'h02920000, 0, 1'b0, 4, 0);    // clr in T4
    gen_instr(32'h02920000, 2, 1'b0, 1, 0);    // clr mid-fetch
    gen_instr(32'h78000000, 0, 1'b0, 6, 2);    // MUL with clr in T6
    gen_instr(32'h02920000, 0, 1'b1, -1, 0);   // back-to-back ADDs
    gen_instr(32'h0A920000, 1, 1'b0, -1, 0);
    gen_instr(32'hF8000000, 0, 1'b0, -1, 3);   // undefined opcode 11111

    // Randomized instruction stream
    for (int k = 0; k < 40; k++) begin
      pick = $urandom_range(0, 9);
      if (pick < 6)      rop = legal_ops[$urandom_range(0, 10)];
      else if (pick < 7) rop = 5'b11011;
      else               rop = 5'($urandom_range(0, 31));
      gen_instr({rop, 27'($urandom)}, $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 7) == 0) ? $urandom_range(0, 6) : -1,
                $urandom_range(1, 4));
    end
    push("final idle", '0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

    run_steps();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/minisrc_control_seq.md
# minisrc_control_seq

Moore control sequencer for the Mini SRC datapath. It walks the fetch cycles (T0–T2) and the execute cycles (T3–T6) for register-to-register ALU instructions, including the MUL/DIV path that writes the 64-bit Z result into HI/LO. It replaces the hand-timed control pulses used in the phase benches. It sits between the datapath's IR output and its control inputs, and waits on memory through a ready handshake during fetch.

## Interface
- No parameters; opcode values and state encodings are constants in the shared package.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `clr`  in  1  synchronous, active-high reset.
- `run`  in  1  level; permits starting the next instruction from IDLE or at instruction end.
- `mem_rdy`  in  1  memory read data valid on Mdatain this cycle.
- `ir`  in  32  datapath IR register output. Fields: op = [31:27], ra = [26:23], rb = [22:19], rc = [18:15].
- `PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin, Yin`  out  1 each  datapath strobes.
- `Zlowin, ZHighin, Zlowout, ZHighout, HIin, LOin`  out  1 each  Z/HI/LO strobes.
- `Gra, Grb, Grc, Rin, Rout`  out  1 each  select-and-encode register controls.
- `operation`  out  5  ALU opcode to the datapath.
- `instr_done`  out  1  single-cycle pulse on the last execute cycle.
- `halted`  out  1  high in HALT.
- `illegal`  out  1  high in ILLEGAL.

## Operation
- States: IDLE, T0, T1, T2, T3, T4, T5, T6, HALT, ILLEGAL.
- Outputs are decoded combinationally from the state register and `ir`. All outputs not listed for a state are 0.
- `operation` is 0 outside T4.
- **IDLE:** all outputs 0. Go to T0 when `run`=1.
- **T0:** PCout, MARin, IncPC, Zlowin. Next state T1.
- **T1:** Zlowout, PCin, Read, MDRin.
  - Stay in T1 while `mem_rdy`=0. Repeating PCin is idempotent because Z is unchanged.
  - Go to T2 on `mem_rdy`=1.
- **T2:** MDRout, IRin. Next state T3.
- **T3:** decode `ir[31:27]`.
  - HALT opcode: go to HALT with no strobes this cycle.
  - Undefined opcode: go to ILLEGAL with no strobes this cycle.
  - Otherwise: Grb, Rout, Yin; next state T4.
- **T4:** Grc, Rout, Zlowin, `operation`=op. ZHighin is also asserted for MUL/DIV. Next state T5.
- **T5, normal ops:** Zlowout, Gra, Rin, `instr_done`. Next state T0 if `run`, else IDLE.
- **T5, MUL/DIV:** Zlowout, LOin. Next state T6.
- **T6:** ZHighout, HIin, `instr_done`. Next state T0 if `run`, else IDLE.
- **HALT, ILLEGAL:** sticky; exited only by `clr`. `halted` or `illegal` is held at 1 and every strobe is 0.
- Supported opcodes: ADD 00000, SUB 00001, AND 00010, OR 00011, SHR 00100, SHRA 00101, SHL 00110, ROR 00111, ROL 01000, MUL 01111, DIV 10000, HALT 11011. All others are illegal.
- `run` is sampled only in IDLE and on the final execute cycle. Dropping `run` mid-instruction does not abort the instruction.

## Timing
- `clr`=1 at a rising edge puts the state in IDLE and drives every output to 0. This applies in any state, including mid-fetch, T6, HALT and ILLEGAL.
- `clr` has priority over `run` and `mem_rdy`.
- Latency with `mem_rdy` high in T1:
  - Normal op: 6 cycles T0→T5.
  - MUL/DIV: 7 cycles T0→T6.
- Each cycle of `mem_rdy`=0 in T1 adds one cycle of latency.
- The IR is loaded at the end of T2. `ir` is first decoded in T3 and must stay stable through the last execute cycle.
- With `run` held high, T0 of the next instruction directly follows T5 or T6; there is no IDLE bubble.

## Configuration
- `MINISRC_MULDIV_EN`
  - Defined: MUL/DIV follow the T4 ZHighin path and the T5 LO / T6 HI path.
  - Undefined: opcodes 01111 and 10000 decode as illegal and go to ILLEGAL at T3. ZHighin, ZHighout, HIin and LOin are tied to 0, and state T6 is unreachable.

## Structure
- Shared package `minisrc_pkg`: 5-bit opcode constants, IR field bit positions, and the state enum typedef (4-bit encoding).
- One sub-module, `minisrc_op_decode`: combinational opcode classification into legal / halt / muldiv flags. It is conditioned on `MINISRC_MULDIV_EN`.
- The top level holds the state register, next-state logic and output decode.

## Test plan
- **Reset/idle:** `clr`=1 for 2 cycles, then `run`=0 → stays in IDLE, all outputs 0, `operation`=0.
- **ADD R5,R2,R4:** `ir`=0x02920000, `mem_rdy`=1, `run` one cycle.
  - Expected: T0–T5 in 6 cycles, `operation`=00000 in T4, Gra+Rin in T5, `instr_done` pulses, then IDLE.
- **DIV R2,R4:** `ir`=0x80120000.
  - Expected: ZHighin+Zlowin in T4, LOin in T5, HIin+`instr_done` in T6, 7 cycles total, `operation`=10000.
  - Repeat with the macro undefined → `illegal`=1 after T3.
- **Memory wait:** `mem_rdy`=0 for 3 cycles in T1.
  - Expected: Read/MDRin held for 4 cycles total, IRin asserted exactly once, ADD completes in 9 cycles.
- **Halt and reset:** `ir`=0xD8000000 (HALT).
  - Expected: `halted`=1 from the cycle after T3, stable for 10 cycles despite `run`=1; `clr` returns to IDLE.
- **Mid-instruction events:**
  - `clr` asserted in T4 → IDLE next cycle, no Rin/LOin pulse.
  - `run` held high across two ADDs → T0 immediately follows T5.
